// File: rtl/alu_pkg.sv
// Shared decode definitions for the RV32IM front end.
//   alu_op_e  : 4-bit ALU operation code seen by the execute stage
//   OP_*      : major opcodes this stage decodes
//   F7_*      : funct7 values that select operation variants
package alu_pkg;

   typedef enum logic [3:0] {
      ALU_AND   = 4'b0000,
      ALU_OR    = 4'b0001,
      ALU_XOR   = 4'b0010,
      ALU_ADD   = 4'b0011,
      ALU_SUB   = 4'b0100,
      ALU_MUL   = 4'b0101,
      ALU_MULH  = 4'b0110,
      ALU_MULHU = 4'b0111,
      ALU_SLL   = 4'b1000,
      ALU_SRL   = 4'b1001,
      ALU_SRA   = 4'b1010,
      ALU_SLT   = 4'b1100,
      ALU_SLTU  = 4'b1101
   } alu_op_e;

   localparam logic [6:0] OP_REG = 7'b0110011;
   localparam logic [6:0] OP_IMM = 7'b0010011;
   localparam logic [6:0] OP_LUI = 7'b0110111;

   localparam logic [6:0] F7_BASE   = 7'b0000000;
   localparam logic [6:0] F7_ALT    = 7'b0100000;
   localparam logic [6:0] F7_MULDIV = 7'b0000001;

endpackage

// File: rtl/regfile.sv
// Architectural register file.
//   clk, rst          : clock, synchronous active-high reset (clears all registers)
//   rs1_addr/rs1_data : combinational read port 1
//   rs2_addr/rs2_data : combinational read port 2
//   we, waddr, wdata  : synchronous write port from writeback
// x0 reads as zero and ignores writes. A write in flight is forwarded to
// a read of the same register in the same cycle.
module regfile #(
   parameter int NREGS = 32,
   parameter int XLEN  = 32,
   parameter int AW    = $clog2(NREGS)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [AW-1:0]   rs1_addr,
   output logic [XLEN-1:0] rs1_data,
   input  logic [AW-1:0]   rs2_addr,
   output logic [XLEN-1:0] rs2_data,
   input  logic            we,
   input  logic [AW-1:0]   waddr,
   input  logic [XLEN-1:0] wdata
);

   logic [XLEN-1:0] regs_q [NREGS];
   logic            wr_en;

   assign wr_en = we && (waddr != '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
      end else if (wr_en) begin
         regs_q[waddr] <= wdata;
      end
   end

   always_comb begin
      rs1_data = regs_q[rs1_addr];
      if (rs1_addr == '0)                     rs1_data = '0;
      else if (wr_en && (waddr == rs1_addr))  rs1_data = wdata;
   end

   always_comb begin
      rs2_data = regs_q[rs2_addr];
      if (rs2_addr == '0)                     rs2_data = '0;
      else if (wr_en && (waddr == rs2_addr))  rs2_data = wdata;
   end

endmodule

// File: rtl/decode_regfile_stage.sv
// Decode / register-read stage feeding the ALU of the 3-stage RV32IM core.
//   clk, rst               : clock, synchronous active-high reset
//   instr, instr_valid     : instruction word and its qualifier
//   stall, flush           : hold EX registers / load a bubble (flush wins)
//   wb_we, wb_rd, wb_data  : register write port from writeback
//   ex_a, ex_b, ex_op      : registered ALU operands and operation
//   ex_rd, ex_we           : registered destination and write enable
//   ex_illegal             : registered undecodable-instruction flag
// Decode and register read are combinational; ex_* appear one cycle later.
module decode_regfile_stage
   import alu_pkg::*;
#(
   parameter int NREGS = 32,
   parameter int XLEN  = 32
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [31:0]              instr,
   input  logic                     instr_valid,
   input  logic                     stall,
   input  logic                     flush,
   input  logic                     wb_we,
   input  logic [$clog2(NREGS)-1:0] wb_rd,
   input  logic [XLEN-1:0]          wb_data,
   output logic [XLEN-1:0]          ex_a,
   output logic [XLEN-1:0]          ex_b,
   output logic [3:0]               ex_op,
   output logic [4:0]               ex_rd,
   output logic                     ex_we,
   output logic                     ex_illegal
);

   logic [6:0]      opcode, funct7;
   logic [2:0]      funct3;
   logic [XLEN-1:0] rs1_data, rs2_data;
   logic [XLEN-1:0] imm_i, imm_sh, imm_u;

   logic            dec_ok;
   alu_op_e         dec_op;
   logic [XLEN-1:0] dec_a, dec_b;

   logic [XLEN-1:0] ex_a_q, ex_a_d, ex_b_q, ex_b_d;
   alu_op_e         ex_op_q, ex_op_d;
   logic [4:0]      ex_rd_q, ex_rd_d;
   logic            ex_we_q, ex_we_d, ex_ill_q, ex_ill_d;

   assign opcode = instr[6:0];
   assign funct3 = instr[14:12];
   assign funct7 = instr[31:25];

   assign imm_i  = {{(XLEN-12){instr[31]}}, instr[31:20]};
   assign imm_sh = {{(XLEN-5){1'b0}}, instr[24:20]};
   assign imm_u  = XLEN'({instr[31:12], 12'b0});

   regfile #(.NREGS(NREGS), .XLEN(XLEN)) u_regfile (
      .clk      (clk),
      .rst      (rst),
      .rs1_addr (instr[19:15]),
      .rs1_data (rs1_data),
      .rs2_addr (instr[24:20]),
      .rs2_data (rs2_data),
      .we       (wb_we),
      .waddr    (wb_rd),
      .wdata    (wb_data)
   );

   always_comb begin
      dec_ok = 1'b0;
      dec_op = ALU_AND;
      dec_a  = rs1_data;
      dec_b  = rs2_data;
      unique case (opcode)
         OP_REG: begin
            unique case (funct7)
               F7_BASE: begin
                  dec_ok = 1'b1;
                  unique case (funct3)
                     3'b000:  dec_op = ALU_ADD;
                     3'b001:  dec_op = ALU_SLL;
                     3'b010:  dec_op = ALU_SLT;
                     3'b011:  dec_op = ALU_SLTU;
                     3'b100:  dec_op = ALU_XOR;
                     3'b101:  dec_op = ALU_SRL;
                     3'b110:  dec_op = ALU_OR;
                     default: dec_op = ALU_AND;
                  endcase
               end
               F7_ALT: begin
                  if (funct3 == 3'b000) begin dec_ok = 1'b1; dec_op = ALU_SUB; end
                  if (funct3 == 3'b101) begin dec_ok = 1'b1; dec_op = ALU_SRA; end
               end
               F7_MULDIV: begin
                  if (funct3 == 3'b000) begin dec_ok = 1'b1; dec_op = ALU_MUL;   end
                  if (funct3 == 3'b001) begin dec_ok = 1'b1; dec_op = ALU_MULH;  end
                  if (funct3 == 3'b011) begin dec_ok = 1'b1; dec_op = ALU_MULHU; end
               end
               default: dec_ok = 1'b0;
            endcase
         end
         OP_IMM: begin
            dec_b  = imm_i;
            dec_ok = 1'b1;
            unique case (funct3)
               3'b000:  dec_op = ALU_ADD;
               3'b010:  dec_op = ALU_SLT;
               3'b011:  dec_op = ALU_SLTU;
               3'b100:  dec_op = ALU_XOR;
               3'b110:  dec_op = ALU_OR;
               3'b111:  dec_op = ALU_AND;
               3'b001: begin
                  dec_b  = imm_sh;
                  dec_op = ALU_SLL;
                  dec_ok = (funct7 == F7_BASE);
               end
               default: begin
                  dec_b  = imm_sh;
                  dec_op = (funct7 == F7_ALT) ? ALU_SRA : ALU_SRL;
                  dec_ok = (funct7 == F7_BASE) || (funct7 == F7_ALT);
               end
            endcase
         end
         OP_LUI: begin
            dec_ok = 1'b1;
            dec_op = ALU_ADD;
            dec_a  = '0;
            dec_b  = imm_u;
         end
         default: dec_ok = 1'b0;
      endcase
   end

   // Priority: flush > stall > bubble > decoded instruction.
   always_comb begin
      ex_a_d   = ex_a_q;
      ex_b_d   = ex_b_q;
      ex_op_d  = ex_op_q;
      ex_rd_d  = ex_rd_q;
      ex_we_d  = ex_we_q;
      ex_ill_d = ex_ill_q;
      if (flush || (!stall && !instr_valid)) begin
         ex_a_d   = '0;
         ex_b_d   = '0;
         ex_op_d  = ALU_AND;
         ex_rd_d  = '0;
         ex_we_d  = 1'b0;
         ex_ill_d = 1'b0;
      end else if (!stall) begin
         ex_a_d   = dec_ok ? dec_a : '0;
         ex_b_d   = dec_ok ? dec_b : '0;
         ex_op_d  = dec_ok ? dec_op : ALU_AND;
         ex_rd_d  = dec_ok ? instr[11:7] : 5'd0;
         ex_we_d  = dec_ok;
         ex_ill_d = !dec_ok;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ex_a_q   <= '0;
         ex_b_q   <= '0;
         ex_op_q  <= ALU_AND;
         ex_rd_q  <= '0;
         ex_we_q  <= 1'b0;
         ex_ill_q <= 1'b0;
      end else begin
         ex_a_q   <= ex_a_d;
         ex_b_q   <= ex_b_d;
         ex_op_q  <= ex_op_d;
         ex_rd_q  <= ex_rd_d;
         ex_we_q  <= ex_we_d;
         ex_ill_q <= ex_ill_d;
      end
   end

   assign ex_a       = ex_a_q;
   assign ex_b       = ex_b_q;
   assign ex_op      = ex_op_q;
   assign ex_rd      = ex_rd_q;
   assign ex_we      = ex_we_q;
   assign ex_illegal = ex_ill_q;

endmodule

// File: tb/tb_decode_regfile_stage.sv
module tb_decode_regfile_stage;

   logic        clk = 1'b0;
   logic        rst, instr_valid, stall, flush, wb_we;
   logic [31:0] instr, wb_data;
   logic [4:0]  wb_rd;
   logic [31:0] ex_a, ex_b;
   logic [3:0]  ex_op;
   logic [4:0]  ex_rd;
   logic        ex_we, ex_illegal;

   int total = 0;
   int bad   = 0;

   decode_regfile_stage dut (
      .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid),
      .stall(stall), .flush(flush), .wb_we(wb_we), .wb_rd(wb_rd),
      .wb_data(wb_data), .ex_a(ex_a), .ex_b(ex_b), .ex_op(ex_op),
      .ex_rd(ex_rd), .ex_we(ex_we), .ex_illegal(ex_illegal)
   );

   always #5 clk = ~clk;

   // Table of every legal instruction pattern: mask, match, ALU op, operand kind.
   // kind: 0 = A=rs1,B=rs2   1 = A=rs1,B=sext imm   2 = A=rs1,B=shamt   3 = A=0,B=upper imm
   logic [31:0] pmask [23];
   logic [31:0] pmatch[23];
   logic [3:0]  pop   [23];
   int          pkind [23];

   task automatic pat(input int i, input logic [31:0] m, input logic [31:0] v,
                      input logic [3:0] o, input int k);
      pmask[i] = m; pmatch[i] = v; pop[i] = o; pkind[i] = k;
   endtask

   initial begin
      pat( 0, 32'hFE00707F, 32'h00000033, 4'b0011, 0); // add
      pat( 1, 32'hFE00707F, 32'h00001033, 4'b1000, 0); // sll
      pat( 2, 32'hFE00707F, 32'h00002033, 4'b1100, 0); // slt
      pat( 3, 32'hFE00707F, 32'h00003033, 4'b1101, 0); // sltu
      pat( 4, 32'hFE00707F, 32'h00004033, 4'b0010, 0); // xor
      pat( 5, 32'hFE00707F, 32'h00005033, 4'b1001, 0); // srl
      pat( 6, 32'hFE00707F, 32'h00006033, 4'b0001, 0); // or
      pat( 7, 32'hFE00707F, 32'h00007033, 4'b0000, 0); // and
      pat( 8, 32'hFE00707F, 32'h40000033, 4'b0100, 0); // sub
      pat( 9, 32'hFE00707F, 32'h40005033, 4'b1010, 0); // sra
      pat(10, 32'hFE00707F, 32'h02000033, 4'b0101, 0); // mul
      pat(11, 32'hFE00707F, 32'h02001033, 4'b0110, 0); // mulh
      pat(12, 32'hFE00707F, 32'h02003033, 4'b0111, 0); // mulhu
      pat(13, 32'h0000707F, 32'h00000013, 4'b0011, 1); // addi
      pat(14, 32'h0000707F, 32'h00002013, 4'b1100, 1); // slti
      pat(15, 32'h0000707F, 32'h00003013, 4'b1101, 1); // sltiu
      pat(16, 32'h0000707F, 32'h00004013, 4'b0010, 1); // xori
      pat(17, 32'h0000707F, 32'h00006013, 4'b0001, 1); // ori
      pat(18, 32'h0000707F, 32'h00007013, 4'b0000, 1); // andi
      pat(19, 32'hFE00707F, 32'h00001013, 4'b1000, 2); // slli
      pat(20, 32'hFE00707F, 32'h00005013, 4'b1001, 2); // srli
      pat(21, 32'hFE00707F, 32'h40005013, 4'b1010, 2); // srai
      pat(22, 32'h0000007F, 32'h00000037, 4'b0011, 3); // lui
   end

   // Behavioural model state
   logic [31:0] mregs [32];
   logic [31:0] e_a, e_b;
   logic [3:0]  e_op;
   logic [4:0]  e_rd;
   logic        e_we, e_ill;
   bit          started = 0;

   function automatic logic [31:0] mread(input int r);
      if (r == 0) return 32'h0;
      if (wb_we && (wb_rd == r[4:0])) return wb_data;
      return mregs[r];
   endfunction

   always @(posedge clk) begin
      logic [31:0] ra, rb;
      int hit;
      started = 1;
      if (rst) begin
         for (int i = 0; i < 32; i++) mregs[i] = 32'h0;
         {e_a, e_b, e_op, e_rd, e_we, e_ill} = '0;
      end else begin
         ra = mread(int'(instr[19:15]));
         rb = mread(int'(instr[24:20]));
         if (flush || (!stall && !instr_valid)) begin
            {e_a, e_b, e_op, e_rd, e_we, e_ill} = '0;
         end else if (!stall) begin
            hit = -1;
            for (int i = 0; i < 23; i++)
               if (hit < 0 && (instr & pmask[i]) == pmatch[i]) hit = i;
            if (hit < 0) begin
               {e_a, e_b, e_op, e_rd, e_we} = '0;
               e_ill = 1'b1;
            end else begin
               e_op = pop[hit]; e_rd = instr[11:7]; e_we = 1'b1; e_ill = 1'b0;
               case (pkind[hit])
                  0: begin e_a = ra; e_b = rb; end
                  1: begin e_a = ra; e_b = $signed(instr) >>> 20; end
                  2: begin e_a = ra; e_b = 32'(instr[24:20]); end
                  default: begin e_a = 32'h0; e_b = instr & 32'hFFFFF000; end
               endcase
            end
         end
         if (wb_we && wb_rd != 5'd0) mregs[wb_rd] = wb_data;
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (started) begin
         chk("model_a",   ex_a, e_a);
         chk("model_b",   ex_b, e_b);
         chk("model_op",  32'(ex_op), 32'(e_op));
         chk("model_rd",  32'(ex_rd), 32'(e_rd));
         chk("model_we",  32'(ex_we), 32'(e_we));
         chk("model_ill", 32'(ex_illegal), 32'(e_ill));
      end
   end

   task automatic step(input logic [31:0] ins, input logic v = 1'b1,
                       input logic st = 1'b0, input logic fl = 1'b0,
                       input logic we = 1'b0, input logic [4:0] rd = 5'd0,
                       input logic [31:0] d = 32'h0, input logic r = 1'b0);
      instr = ins; instr_valid = v; stall = st; flush = fl;
      wb_we = we; wb_rd = rd; wb_data = d; rst = r;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic chk_all_zero(input string nm);
      chk({nm, "_a"}, ex_a, 32'h0);
      chk({nm, "_b"}, ex_b, 32'h0);
      chk({nm, "_op_rd_we_ill"}, {21'h0, ex_op, ex_rd, ex_we, ex_illegal}, 32'h0);
   endtask

   initial begin
      logic [31:0] held_a, held_b;
      logic [31:0] rnd;
      rst = 1'b1; instr = 32'h0; instr_valid = 1'b0; stall = 1'b0; flush = 1'b0;
      wb_we = 1'b0; wb_rd = 5'd0; wb_data = 32'h0;
      @(negedge clk);
      step(32'h00500093, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1);
      chk_all_zero("reset");

      step(32'h00500093);                                       // addi x1,x0,5
      chk("addi_a", ex_a, 32'h0);
      chk("addi_b", ex_b, 32'h5);
      chk("addi_op", 32'(ex_op), 32'h3);
      chk("addi_rd", 32'(ex_rd), 32'h1);
      chk("addi_we", 32'(ex_we), 32'h1);

      step(32'h000101B3, 1'b1, 1'b0, 1'b0, 1'b1, 5'd2, 32'hDEADBEEF); // add x3,x2,x0 + bypass
      chk("bypass_a", ex_a, 32'hDEADBEEF);
      step(32'h00000233, 1'b1, 1'b0, 1'b0, 1'b1, 5'd0, 32'h7);        // add x4,x0,x0, wr x0
      chk("x0_a", ex_a, 32'h0);
      step(32'h00000233);
      chk("x0_after", ex_a, 32'h0);

      step(32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd1, 32'h80000000);       // bubble, x1 <= 0x80000000
      chk("bubble_ill", 32'(ex_illegal), 32'h0);
      step(32'h4040D293);                                       // srai x5,x1,4
      chk("srai_op", 32'(ex_op), 32'hA);
      chk("srai_a", ex_a, 32'h80000000);
      chk("srai_b", ex_b, 32'h4);
      step(32'h12345337);                                       // lui x6,0x12345
      chk("lui_a", ex_a, 32'h0);
      chk("lui_b", ex_b, 32'h12345000);
      chk("lui_op", 32'(ex_op), 32'h3);

      step(32'h022093B3);                                       // mulh x7,x1,x2
      chk("mulh_op", 32'(ex_op), 32'h6);
      chk("mulh_b", ex_b, 32'hDEADBEEF);
      step(32'h0220A3B3);                                       // mulhsu -> illegal
      chk("mulhsu_ill", 32'(ex_illegal), 32'h1);
      chk("mulhsu_we", 32'(ex_we), 32'h0);
      chk("mulhsu_rd", 32'(ex_rd), 32'h0);
      step(32'h0000007F);
      chk("badop_ill", 32'(ex_illegal), 32'h1);
      step(32'h40001013);                                       // slli with f7=0100000
      chk("slli_bad_ill", 32'(ex_illegal), 32'h1);
      step(32'h02C0C033);                                       // div -> illegal
      chk("div_ill", 32'(ex_illegal), 32'h1);
      step(32'hFFF0C013);                                       // xori x0,x1,-1
      chk("xori_b", ex_b, 32'hFFFFFFFF);

      step(32'h00100093);                                       // addi x1,x0,1
      held_a = ex_a; held_b = ex_b;
      chk("pre_stall_b", held_b, 32'h1);
      for (int i = 0; i < 3; i++) begin
         step(32'h12345337 + 32'(i), 1'b1, 1'b1, 1'b0, 1'b1, 5'd10, 32'(100 + i));
         chk("stall_b", ex_b, 32'h1);
         chk("stall_rd", 32'(ex_rd), 32'h1);
      end
      step(32'h00050033);                                       // add x0,x10,x0: write during stall
      chk("stall_wr_a", ex_a, 32'd102);
      step(32'h00100093, 1'b1, 1'b1, 1'b1);                     // stall+flush
      chk_all_zero("stflush");

      step(32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd8, 32'd9);         // x8 <= 9
      step(32'h000404B3);                                       // add x9,x8,x0
      chk("x8_a", ex_a, 32'd9);
      step(32'h000404B3, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1);
      chk_all_zero("midrst");
      step(32'h000404B3);
      chk("x8_cleared", ex_a, 32'h0);

      for (int i = 0; i < 80; i++) begin
         rnd = $urandom;
         case (i % 4)
            0: rnd[6:0] = 7'b0110011;
            1: rnd[6:0] = 7'b0010011;
            2: begin rnd[6:0] = 7'b0110011; rnd[31:25] = (i % 8 == 2) ? 7'b0000001 : 7'b0100000; end
            default: ;
         endcase
         step(rnd, ($urandom_range(0, 7) != 0), ($urandom_range(0, 5) == 0),
              ($urandom_range(0, 9) == 0), ($urandom_range(0, 1) == 1),
              5'($urandom_range(0, 31)), $urandom);
      end

      @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
